// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pipe_hazard_ctrl : stage enables, PC enable and flush pulses for a 5-stage
//                    pipeline (load-use, branch redirect, mem wait, halt).
// Revision 1.0
// ----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int RegAddrBits = 5,
  parameter int CntBits     = 16
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   Tick,
  input  logic                   ex_mem_read,
  input  logic [RegAddrBits-1:0] ex_rd,
  input  logic [RegAddrBits-1:0] id_rs1,
  input  logic [RegAddrBits-1:0] id_rs2,
  input  logic                   id_use_rs1,
  input  logic                   id_use_rs2,
  input  logic                   branch_taken,
  input  logic                   mem_busy,
  input  logic                   halt_req,
  input  logic                   resume,
  output logic                   pc_en,
  output logic                   en_if_id,
  output logic                   en_id_ex,
  output logic                   en_ex_mem,
  output logic                   en_mem_wb,
  output logic                   flush_if_id,
  output logic                   flush_id_ex,
  output logic                   halted,
  output logic [CntBits-1:0]     stall_cnt
);

  typedef enum logic [1:0] {
    S_RUN        = 2'd0,
    S_LOAD_STALL = 2'd1,
    S_MEM_WAIT   = 2'd2,
    S_HALTED     = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic                 pending_q, pending_d;
  logic                 flush_if_id_q, flush_if_id_d;
  logic                 flush_id_ex_q, flush_id_ex_d;
  logic [CntBits-1:0]   stall_cnt_q, stall_cnt_d;

  logic                 load_use;
  logic                 en_front;
  logic                 en_back;

  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));

  // MEM_WAIT exit is evaluated exactly like RUN, with the latched branch
  // treated as if EX were still reporting it.
  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    flush_if_id_d = 1'b0;
    flush_id_ex_d = 1'b0;
    en_front      = 1'b0;
    en_back       = 1'b0;

    if (Tick) begin
      case (state_q)
        S_HALTED: begin
          if (resume) state_d = S_RUN;
        end
        default: begin
          if (mem_busy) begin
            state_d   = S_MEM_WAIT;
            pending_d = pending_q | branch_taken;
          end else if (branch_taken || pending_q) begin
            en_front      = 1'b1;
            en_back       = 1'b1;
            flush_if_id_d = 1'b1;
            flush_id_ex_d = 1'b1;
            pending_d     = 1'b0;
            state_d       = S_RUN;
          end else if (load_use && (state_q != S_LOAD_STALL)) begin
            en_back       = 1'b1;
            flush_id_ex_d = 1'b1;
            state_d       = S_LOAD_STALL;
          end else if (halt_req) begin
            state_d = S_HALTED;
          end else begin
            en_front = 1'b1;
            en_back  = 1'b1;
            state_d  = S_RUN;
          end
        end
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (Tick && !en_front && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CntBits'(1);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q       <= S_RUN;
      pending_q     <= 1'b0;
      flush_if_id_q <= 1'b0;
      flush_id_ex_q <= 1'b0;
      stall_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      flush_if_id_q <= flush_if_id_d;
      flush_id_ex_q <= flush_id_ex_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign pc_en       = en_front;
  assign en_if_id    = en_front;
  assign en_id_ex    = en_back;
  assign en_ex_mem   = en_back;
  assign en_mem_wb   = en_back;
  assign flush_if_id = flush_if_id_q;
  assign flush_id_ex = flush_id_ex_q;
  assign halted      = (state_q == S_HALTED);
  assign stall_cnt   = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl : directed + random bench with a behavioural model.
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  localparam int CNT     = 4;
  localparam int CNT_MAX = (1 << CNT) - 1;

  logic           Clock = 1'b0;
  logic           Reset;
  logic           Tick;
  logic           ex_mem_read;
  logic [4:0]     ex_rd, id_rs1, id_rs2;
  logic           id_use_rs1, id_use_rs2;
  logic           branch_taken, mem_busy, halt_req, resume;
  logic           pc_en, en_if_id, en_id_ex, en_ex_mem, en_mem_wb;
  logic           flush_if_id, flush_id_ex, halted;
  logic [CNT-1:0] stall_cnt;

  int checks   = 0;
  int failures = 0;

  pipe_hazard_ctrl #(.RegAddrBits(5), .CntBits(CNT)) dut (
    .Clock(Clock), .Reset(Reset), .Tick(Tick),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .branch_taken(branch_taken), .mem_busy(mem_busy),
    .halt_req(halt_req), .resume(resume),
    .pc_en(pc_en), .en_if_id(en_if_id), .en_id_ex(en_id_ex),
    .en_ex_mem(en_ex_mem), .en_mem_wb(en_mem_wb),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .halted(halted), .stall_cnt(stall_cnt)
  );

  always #5 Clock = ~Clock;

  // Model: pipeline frozen (halted), one-shot load bubble already taken,
  // a redirect owed after the memory wait, stall count, expected flushes.
  bit m_halted, m_after_load, m_pending, m_fa, m_fb;
  int m_cnt;
  bit e_front, e_back, e_fa, e_fb, e_halt_n, e_after_n, e_pend_n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic predict();
    bit lu;
    lu = ex_mem_read && (ex_rd != 0) &&
         ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    e_front = 0; e_back = 0; e_fa = 0; e_fb = 0;
    e_halt_n = m_halted; e_after_n = m_after_load; e_pend_n = m_pending;
    if (Tick) begin
      e_after_n = 0;
      if (m_halted) begin
        if (resume) e_halt_n = 0;
      end else if (mem_busy) begin
        e_pend_n = m_pending | branch_taken;
      end else if (branch_taken || m_pending) begin
        e_front = 1; e_back = 1; e_fa = 1; e_fb = 1; e_pend_n = 0;
      end else if (lu && !m_after_load) begin
        e_back = 1; e_fb = 1; e_after_n = 1;
      end else if (halt_req) begin
        e_halt_n = 1;
      end else begin
        e_front = 1; e_back = 1;
      end
    end
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, "_flush"}, {30'd0, flush_if_id, flush_id_ex}, {30'd0, m_fa, m_fb});
    chk({tag, "_halted"}, {31'd0, halted}, {31'd0, m_halted});
    chk({tag, "_cnt"}, {28'd0, stall_cnt}, m_cnt);
  endtask

  // Starts and ends at posedge+1 with inputs already driven.
  task automatic cycle(input string tag);
    #3;
    predict();
    chk({tag, "_en"}, {27'd0, pc_en, en_if_id, en_id_ex, en_ex_mem, en_mem_wb},
        {27'd0, e_front, e_front, e_back, e_back, e_back});
    @(posedge Clock);
    m_fa = e_fa; m_fb = e_fb;
    if (Tick) begin
      m_halted = e_halt_n; m_after_load = e_after_n; m_pending = e_pend_n;
      if (!e_front && m_cnt < CNT_MAX) m_cnt++;
    end
    #1;
    chk_regs(tag);
  endtask

  task automatic do_reset(input string tag);
    Reset = 1'b1;
    #2;
    m_halted = 0; m_after_load = 0; m_pending = 0; m_fa = 0; m_fb = 0; m_cnt = 0;
    chk_regs(tag);
    predict();
    chk({tag, "_en"}, {27'd0, pc_en, en_if_id, en_id_ex, en_ex_mem, en_mem_wb},
        {27'd0, e_front, e_front, e_back, e_back, e_back});
    @(posedge Clock);
    #1;
    Reset = 1'b0;
  endtask

  task automatic set_idle();
    Tick = 1; ex_mem_read = 0; ex_rd = 0; id_rs1 = 0; id_rs2 = 0;
    id_use_rs1 = 0; id_use_rs2 = 0; branch_taken = 0; mem_busy = 0;
    halt_req = 0; resume = 0;
  endtask

  initial begin
    set_idle();
    Reset = 1'b0;
    #1;
    do_reset("rst0");

    for (int i = 0; i < 8; i++) cycle("idle");
    chk("idle_cnt_zero", {28'd0, stall_cnt}, 0);
    chk("idle_en_all", {27'd0, pc_en, en_if_id, en_id_ex, en_ex_mem, en_mem_wb}, 32'h1f);

    // load-use on rs1
    ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
    cycle("lu");
    chk("lu_flush_id_ex", {31'd0, flush_id_ex}, 1);
    chk("lu_flush_if_id", {31'd0, flush_if_id}, 0);
    chk("lu_cnt_one", {28'd0, stall_cnt}, 1);
    set_idle();
    cycle("lu_after");
    chk("lu_after_flush", {31'd0, flush_id_ex}, 0);

    // ex_rd == 0 never stalls
    ex_mem_read = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1;
    cycle("rd0");
    chk("rd0_pc_en", {31'd0, pc_en}, 1);
    set_idle();

    // branch coincident with load-use
    ex_mem_read = 1; ex_rd = 7; id_rs2 = 7; id_use_rs2 = 1; branch_taken = 1;
    cycle("br_lu");
    chk("br_lu_flushes", {30'd0, flush_if_id, flush_id_ex}, 3);
    chk("br_lu_cnt", {28'd0, stall_cnt}, 1);
    set_idle();
    cycle("br_after");

    // mem_busy x3 with branch in cycle 2
    do_reset("rst_mem");
    mem_busy = 1; cycle("mw1");
    branch_taken = 1; cycle("mw2");
    branch_taken = 0; cycle("mw3");
    chk("mw_no_flush_yet", {30'd0, flush_if_id, flush_id_ex}, 0);
    mem_busy = 0; cycle("mw_exit");
    chk("mw_exit_flushes", {30'd0, flush_if_id, flush_id_ex}, 3);
    chk("mw_cnt_three", {28'd0, stall_cnt}, 3);
    cycle("mw_post");

    // halt for five cycles
    do_reset("rst_halt");
    halt_req = 1; cycle("h_req");
    halt_req = 0;
    chk("h_halted", {31'd0, halted}, 1);
    for (int i = 0; i < 4; i++) cycle("h_wait");
    resume = 1; halt_req = 1; cycle("h_resume");
    chk("h_released", {31'd0, halted}, 0);
    chk("h_cnt", {28'd0, stall_cnt}, 6);
    set_idle();
    cycle("h_run");

    // reset mid-MEM_WAIT, then Tick toggling
    mem_busy = 1; cycle("rmw1"); cycle("rmw2");
    set_idle();
    do_reset("rst_mid");
    chk("rst_mid_cnt", {28'd0, stall_cnt}, 0);
    for (int i = 0; i < 6; i++) begin
      Tick = i[0];
      branch_taken = (i == 2);
      cycle("tick_tog");
    end
    chk("tick_tog_cnt", {28'd0, stall_cnt}, 0);
    set_idle();

    // saturation of the stall counter
    halt_req = 1;
    for (int i = 0; i < 20; i++) cycle("sat");
    chk("sat_cnt", {28'd0, stall_cnt}, CNT_MAX);
    set_idle();
    resume = 1; cycle("sat_exit");
    set_idle();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99) == 0) begin
        do_reset("rnd_rst");
      end else begin
        Tick         = ($urandom_range(9) < 8);
        ex_mem_read  = $urandom_range(1);
        ex_rd        = 5'($urandom_range(3));
        id_rs1       = 5'($urandom_range(3));
        id_rs2       = 5'($urandom_range(3));
        id_use_rs1   = $urandom_range(1);
        id_use_rs2   = $urandom_range(1);
        branch_taken = ($urandom_range(9) < 2);
        mem_busy     = ($urandom_range(9) < 2);
        halt_req     = ($urandom_range(19) == 0);
        resume       = ($urandom_range(3) == 0);
        cycle("rnd");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
